// File: rtl/ariane_axi_pkg.sv
// AXI4 request/response bundles for the SoC bus side of the debug bridge.
// Widths: 4-bit ID, 64-bit address and data.
package ariane_axi;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
    } ax_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

// File: rtl/dm_bridge_pkg.sv
// Shared types and constants for the debug-memory AXI slave bridge.
// Optional burst support is selected with DM_SLV_BRIDGE_BURST_EN.
package dm_bridge_pkg;
    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] MAX_SIZE = 3'd3;

    // FIXED and INCR are the only burst kinds the bridge can serve
    function automatic logic burst_supported(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction
endpackage

// File: rtl/dm_bridge_addr_gen.sv
// Next-beat address and unsupported-transaction decode for the bridge.
// With DM_SLV_BRIDGE_BURST_EN undefined, only single beats are legal.
module dm_bridge_addr_gen
    import dm_bridge_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]                size_i,
    input  logic [1:0]                burst_i,
    input  logic [7:0]                len_i,
    output logic [AXI_ADDR_WIDTH-1:0] next_addr_o,
    output logic                      err_o
);

`ifdef DM_SLV_BRIDGE_BURST_EN
    logic unused_len;
    assign unused_len = ^len_i;

    // INCR steps by the beat size with modular wrap; FIXED stays put
    always_comb begin
        next_addr_o = addr_i;
        if (burst_i == BURST_INCR) begin
            next_addr_o = addr_i + (AXI_ADDR_WIDTH'(1) << size_i);
        end
        err_o = !burst_supported(burst_i) || (size_i > MAX_SIZE);
    end
`else
    // Single-beat build: address never advances, any burst is an error
    always_comb begin
        next_addr_o = addr_i;
        err_o = !burst_supported(burst_i) || (size_i > MAX_SIZE)
              || (len_i != 8'd0);
    end
`endif

endmodule

// File: rtl/dm_slave_axi_bridge.sv
// AXI4 slave to debug-memory bridge: one transaction at a time, split into
// single-beat strobes. Burst support is enabled by DM_SLV_BRIDGE_BURST_EN.
module dm_slave_axi_bridge
    import dm_bridge_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  ariane_axi::req_t          axi_req_i,
    output ariane_axi::resp_t         axi_resp_o,
    output logic                      slave_req_o,
    output logic                      slave_we_o,
    output logic [AXI_ADDR_WIDTH-1:0] slave_addr_o,
    output logic [AXI_STRB_WIDTH-1:0] slave_be_o,
    output logic [AXI_DATA_WIDTH-1:0] slave_wdata_o,
    input  logic [AXI_DATA_WIDTH-1:0] slave_rdata_i
);

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]                id_q, id_d;
    logic [7:0]                len_q, len_d;
    logic [2:0]                size_q, size_d;
    logic [1:0]                burst_q, burst_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      fresh_q, fresh_d;
    logic                      wr_prio_q, wr_prio_d;

    logic [AXI_ADDR_WIDTH-1:0] next_addr;
    logic                      err;
    logic                      is_last;
    logic                      pick_w;
    logic                      pick_r;

    logic unused_axi;
    assign unused_axi = ^{axi_req_i.aw.lock, axi_req_i.aw.cache,
                          axi_req_i.aw.prot, axi_req_i.aw.qos,
                          axi_req_i.ar.lock, axi_req_i.ar.cache,
                          axi_req_i.ar.prot, axi_req_i.ar.qos,
                          axi_req_i.w.last};

    dm_bridge_addr_gen #(
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)
    ) u_addr_gen (
        .addr_i     (addr_q),
        .size_i     (size_q),
        .burst_i    (burst_q),
        .len_i      (len_q),
        .next_addr_o(next_addr),
        .err_o      (err)
    );

    assign is_last = (cnt_q == len_q);
    assign pick_w  = axi_req_i.aw_valid
                   && (!axi_req_i.ar_valid || wr_prio_q);
    assign pick_r  = axi_req_i.ar_valid && !pick_w;

    // Next-state, AXI handshakes and memory strobe generation
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        id_d      = id_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        fresh_d   = 1'b0;
        wr_prio_d = wr_prio_q;

        axi_resp_o    = '0;
        slave_req_o   = 1'b0;
        slave_we_o    = 1'b0;
        slave_addr_o  = {addr_q[AXI_ADDR_WIDTH-1:3], 3'b000};
        slave_be_o    = '0;
        slave_wdata_o = '0;

        unique case (state_q)
            IDLE: begin
                if (!rst_i && pick_w) begin
                    axi_resp_o.aw_ready = 1'b1;
                    addr_d    = AXI_ADDR_WIDTH'(axi_req_i.aw.addr);
                    id_d      = axi_req_i.aw.id;
                    len_d     = axi_req_i.aw.len;
                    size_d    = axi_req_i.aw.size;
                    burst_d   = axi_req_i.aw.burst;
                    cnt_d     = 8'd0;
                    wr_prio_d = !wr_prio_q;
                    state_d   = WR_DATA;
                end else if (!rst_i && pick_r) begin
                    axi_resp_o.ar_ready = 1'b1;
                    addr_d    = AXI_ADDR_WIDTH'(axi_req_i.ar.addr);
                    id_d      = axi_req_i.ar.id;
                    len_d     = axi_req_i.ar.len;
                    size_d    = axi_req_i.ar.size;
                    burst_d   = axi_req_i.ar.burst;
                    cnt_d     = 8'd0;
                    wr_prio_d = !wr_prio_q;
                    state_d   = RD_REQ;
                end
            end
            RD_REQ: begin
                if (!err) begin
                    slave_req_o = 1'b1;
                    slave_be_o  = '1;
                end
                fresh_d = 1'b1;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (fresh_q) begin
                    rdata_d = slave_rdata_i;
                end
                axi_resp_o.r_valid = 1'b1;
                axi_resp_o.r.id    = id_q;
                axi_resp_o.r.last  = is_last;
                if (err) begin
                    axi_resp_o.r.resp = RESP_SLVERR;
                    axi_resp_o.r.data = '0;
                end else begin
                    axi_resp_o.r.resp = RESP_OKAY;
                    axi_resp_o.r.data = fresh_q ? slave_rdata_i : rdata_q;
                end
                if (axi_req_i.r_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                axi_resp_o.w_ready = 1'b1;
                if (axi_req_i.w_valid) begin
                    if (!err) begin
                        slave_req_o   = 1'b1;
                        slave_we_o    = 1'b1;
                        slave_be_o    = axi_req_i.w.strb;
                        slave_wdata_o = axi_req_i.w.data;
                    end
                    if (is_last) begin
                        state_d = WR_RESP;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = next_addr;
                    end
                end
            end
            WR_RESP: begin
                axi_resp_o.b_valid = 1'b1;
                axi_resp_o.b.id    = id_q;
                axi_resp_o.b.resp  = err ? RESP_SLVERR : RESP_OKAY;
                if (axi_req_i.b_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transaction registers; reset drops any in-flight access
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            id_q      <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            fresh_q   <= 1'b0;
            wr_prio_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            fresh_q   <= fresh_d;
            wr_prio_q <= wr_prio_d;
        end
    end

endmodule

// File: tb/tb_dm_slave_axi_bridge.sv
// Self-checking bench for dm_slave_axi_bridge: vector table, hand-written
// corner sequences and randomized transactions against a behavioural model.
module tb_dm_slave_axi_bridge;
    logic              clk = 1'b0;
    logic              rst;
    ariane_axi::req_t  req;
    ariane_axi::resp_t resp;
    logic              sreq;
    logic              swe;
    logic [63:0]       saddr;
    logic [7:0]        sbe;
    logic [63:0]       swdata;
    logic [63:0]       srdata = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
    } strobe_t;

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  resp;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } vec_t;

    strobe_t strobes[$];
    vec_t    vecs[11];

    dm_slave_axi_bridge dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .axi_req_i    (req),
        .axi_resp_o   (resp),
        .slave_req_o  (sreq),
        .slave_we_o   (swe),
        .slave_addr_o (saddr),
        .slave_be_o   (sbe),
        .slave_wdata_o(swdata),
        .slave_rdata_i(srdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] memfn(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_1234, a[31:0] + 32'h1111_0000};
    endfunction

    // Memory: read data valid only the cycle after a read strobe
    always @(posedge clk) begin
        if (sreq && !swe) srdata <= memfn(saddr);
        else srdata <= {$urandom, $urandom};
    end

    always @(negedge clk) begin
        if (!rst && sreq) strobes.push_back('{swe, saddr, sbe, swdata});
    end

    function automatic logic [63:0] beat_addr(input logic [63:0] a,
                                              input logic [2:0] size,
                                              input logic [1:0] burst,
                                              input int k);
        if (burst == 2'b01) return a + 64'(k) * (64'd1 << size);
        return a;
    endfunction

    function automatic bit model_err(input logic [7:0] len,
                                     input logic [2:0] size,
                                     input logic [1:0] burst);
        bit e;
        e = (burst == 2'b10) || (size > 3'd3);
`ifndef DM_SLV_BRIDGE_BURST_EN
        if (len != 8'd0) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst,
                           input logic [1:0] exp_resp);
        int n;
        bit done;
        bit held;
        bit err;
        logic [63:0] hd;
        logic [63:0] ea;
        err = (exp_resp == 2'b10);
        strobes.delete();
        req.ar = '0;
        req.ar.id = id;
        req.ar.addr = addr;
        req.ar.len = len;
        req.ar.size = size;
        req.ar.burst = burst;
        req.ar_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!resp.ar_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ar_ready", 64'(resp.ar_ready), 64'd1);
        tick();
        req.ar_valid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            ea = beat_addr(addr, size, burst, k) & ~64'h7;
            done = 1'b0;
            held = 1'b0;
            n = 0;
            while (!done && n < 40) begin
                req.r_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (resp.r_valid) begin
                    if (held) check("r_hold", resp.r.data, hd);
                    if (req.r_ready) begin
                        check("r_data", resp.r.data,
                              err ? 64'd0 : memfn(ea));
                        check("r_resp", 64'(resp.r.resp), 64'(exp_resp));
                        check("r_last", 64'(resp.r.last),
                              (k == int'(len)) ? 64'd1 : 64'd0);
                        check("r_id", 64'(resp.r.id), 64'(id));
                        done = 1'b1;
                    end else begin
                        held = 1'b1;
                        hd = resp.r.data;
                    end
                end
                tick();
                n++;
            end
            if (!done) check("r_timeout", 64'd0, 64'd1);
        end
        req.r_ready = 1'b0;
        check("rd_strobes", 64'(strobes.size()),
              err ? 64'd0 : 64'(len) + 64'd1);
        for (int i = 0; i < strobes.size() && i <= int'(len); i++) begin
            ea = beat_addr(addr, size, burst, i) & ~64'h7;
            check("rd_stb_addr", strobes[i].addr, ea);
            check("rd_stb_ctl", 64'({strobes[i].we, strobes[i].be}),
                  64'({1'b0, 8'hFF}));
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst,
                            input logic [1:0] exp_resp,
                            input logic [63:0] d0, input logic [7:0] s0);
        int n;
        bit done;
        bit err;
        logic [63:0] d;
        logic [7:0] s;
        logic [63:0] ed[$];
        logic [7:0] es[$];
        err = (exp_resp == 2'b10);
        strobes.delete();
        req.aw = '0;
        req.aw.id = id;
        req.aw.addr = addr;
        req.aw.len = len;
        req.aw.size = size;
        req.aw.burst = burst;
        req.aw_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!resp.aw_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("aw_ready", 64'(resp.aw_ready), 64'd1);
        tick();
        req.aw_valid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            d = (k == 0 && s0 != 0) ? d0 : {$urandom, $urandom};
            s = (k == 0 && s0 != 0) ? s0 : 8'($urandom);
            ed.push_back(d);
            es.push_back(s);
            done = 1'b0;
            n = 0;
            while (!done && n < 40) begin
                req.w_valid = ($urandom_range(0, 3) != 0);
                req.w.data = d;
                req.w.strb = s;
                req.w.last = (k == int'(len));
                @(negedge clk);
                if (req.w_valid && resp.w_ready) done = 1'b1;
                tick();
                n++;
            end
            if (!done) check("w_timeout", 64'd0, 64'd1);
        end
        req.w_valid = 1'b0;
        done = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            req.b_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (resp.b_valid && req.b_ready) begin
                check("b_id", 64'(resp.b.id), 64'(id));
                check("b_resp", 64'(resp.b.resp), 64'(exp_resp));
                done = 1'b1;
            end
            tick();
            n++;
        end
        if (!done) check("b_timeout", 64'd0, 64'd1);
        req.b_ready = 1'b0;
        check("wr_strobes", 64'(strobes.size()),
              err ? 64'd0 : 64'(len) + 64'd1);
        for (int i = 0; i < strobes.size() && i <= int'(len); i++) begin
            check("wr_stb_addr", strobes[i].addr,
                  beat_addr(addr, size, burst, i) & ~64'h7);
            check("wr_stb_ctl", 64'({strobes[i].we, strobes[i].be}),
                  64'({1'b1, es[i]}));
            check("wr_stb_data", strobes[i].wdata, ed[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] bok;
`ifdef DM_SLV_BRIDGE_BURST_EN
        bok = 2'b00;
`else
        bok = 2'b10;
`endif
        vecs[0]  = '{0, 4'd3, 64'h800, 8'd0, 3'd3, 2'b01, 2'b00, 64'h0, 8'h0};
        vecs[1]  = '{1, 4'd5, 64'h10C, 8'd0, 3'd3, 2'b01, 2'b00,
                     64'hDEADBEEF_00000000, 8'hF0};
        vecs[2]  = '{0, 4'd7, 64'h400, 8'd3, 3'd3, 2'b01, bok, 64'h0, 8'h0};
        vecs[3]  = '{0, 4'd1, 64'h200, 8'd1, 3'd3, 2'b10, 2'b10, 64'h0, 8'h0};
        vecs[4]  = '{0, 4'd2, 64'h208, 8'd0, 3'd4, 2'b00, 2'b10, 64'h0, 8'h0};
        vecs[5]  = '{1, 4'd9, 64'h1000, 8'd2, 3'd2, 2'b01, bok, 64'h0, 8'h0};
        vecs[6]  = '{1, 4'd4, 64'h2000, 8'd1, 3'd3, 2'b00, bok, 64'h0, 8'h0};
        vecs[7]  = '{1, 4'd6, 64'h2100, 8'd0, 3'd3, 2'b10, 2'b10, 64'h0, 8'h0};
        vecs[8]  = '{0, 4'd8, 64'h3008, 8'd2, 3'd3, 2'b00, bok, 64'h0, 8'h0};
        vecs[9]  = '{0, 4'hA, 64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, 2'b01,
                     bok, 64'h0, 8'h0};
        vecs[10] = '{0, 4'hB, 64'h5, 8'd3, 3'd0, 2'b01, bok, 64'h0, 8'h0};

        // Reset: every ready/valid low even with requests pending
        rst = 1'b1;
        req = '0;
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        req.w_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_aw_ready", 64'(resp.aw_ready), 64'd0);
        check("rst_ar_ready", 64'(resp.ar_ready), 64'd0);
        check("rst_w_ready", 64'(resp.w_ready), 64'd0);
        check("rst_valids", 64'({resp.r_valid, resp.b_valid}), 64'd0);
        check("rst_slave_req", 64'(sreq), 64'd0);
        req = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        req.w_valid = 1'b1;
        @(negedge clk);
        check("w_before_aw", 64'({resp.w_ready, sreq}), 64'd0);
        tick();
        req.w_valid = 1'b0;

        // Single read latency: strobe in N+1, rvalid in N+2
        req.ar = '0;
        req.ar.id = 4'd3;
        req.ar.addr = 64'h800;
        req.ar.size = 3'd3;
        req.ar.burst = 2'b01;
        req.ar_valid = 1'b1;
        @(negedge clk);
        check("lat_ar_ready", 64'(resp.ar_ready), 64'd1);
        tick();
        req.ar_valid = 1'b0;
        req.r_ready = 1'b1;
        @(negedge clk);
        check("lat_strobe", 64'({sreq, swe, sbe, resp.r_valid}),
              64'({1'b1, 1'b0, 8'hFF, 1'b0}));
        check("lat_addr", saddr, 64'h800);
        tick();
        @(negedge clk);
        check("lat_rvalid", 64'({resp.r_valid, resp.r.last, resp.r.id,
              resp.r.resp}), 64'({1'b1, 1'b1, 4'd3, 2'b00}));
        check("lat_rdata", resp.r.data, memfn(64'h800));
        tick();
        req.r_ready = 1'b0;
        @(negedge clk);
        check("lat_rvalid_off", 64'(resp.r_valid), 64'd0);
        tick();

        // Vector table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr)
                do_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size,
                         vecs[i].burst, vecs[i].resp, vecs[i].wdata,
                         vecs[i].wstrb);
            else
                do_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size,
                        vecs[i].burst, vecs[i].resp);
        end

        // Reset pulsed while a read beat waits for rready
        req.ar = '0;
        req.ar.id = 4'd2;
        req.ar.addr = 64'h900;
        req.ar.size = 3'd3;
        req.ar.burst = 2'b01;
        req.ar_valid = 1'b1;
        @(negedge clk);
        tick();
        req.ar_valid = 1'b0;
        req.r_ready = 1'b0;
        tick();
        @(negedge clk);
        check("rst_mid_pre", 64'(resp.r_valid), 64'd1);
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_rvalid", 64'({resp.r_valid, sreq}), 64'd0);
        req.ar_valid = 1'b1;
        @(negedge clk);
        check("rst_mid_ar_blk", 64'(resp.ar_ready), 64'd0);
        tick();
        rst = 1'b0;
        req.ar_valid = 1'b0;
        do_read(4'd6, 64'hA00, 8'd0, 3'd3, 2'b01, 2'b00);

        // Collisions: write first after reset, then read wins
        do_reset();
        req.aw.id = 4'd1;
        req.aw.addr = 64'h40;
        req.aw.size = 3'd3;
        req.aw.burst = 2'b01;
        req.ar.id = 4'd2;
        req.ar.addr = 64'h48;
        req.ar.size = 3'd3;
        req.ar.burst = 2'b01;
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        @(negedge clk);
        check("coll1_ready", 64'({resp.aw_ready, resp.ar_ready}), 64'b10);
        tick();
        req.aw_valid = 1'b0;
        req.w_valid = 1'b1;
        req.w.data = 64'h1234;
        req.w.strb = 8'hFF;
        req.b_ready = 1'b1;
        @(negedge clk);
        check("coll1_w", 64'({resp.w_ready, sreq, swe, resp.ar_ready}),
              64'b1110);
        check("coll1_w_addr", saddr, 64'h40);
        tick();
        req.w_valid = 1'b0;
        req.aw_valid = 1'b1;
        @(negedge clk);
        check("coll1_b", 64'({resp.b_valid, resp.b.id}), 64'({1'b1, 4'd1}));
        tick();
        @(negedge clk);
        check("coll2_ready", 64'({resp.aw_ready, resp.ar_ready}), 64'b01);
        tick();
        req.ar_valid = 1'b0;
        req.r_ready = 1'b1;
        @(negedge clk);
        check("coll2_strobe", saddr, 64'h48);
        tick();
        @(negedge clk);
        check("coll2_r", 64'({resp.r_valid, resp.r.id}), 64'({1'b1, 4'd2}));
        tick();
        req.r_ready = 1'b0;
        @(negedge clk);
        check("coll3_aw", 64'(resp.aw_ready), 64'd1);
        tick();
        req.aw_valid = 1'b0;
        req.w_valid = 1'b1;
        @(negedge clk);
        tick();
        req.w_valid = 1'b0;
        @(negedge clk);
        check("coll3_b", 64'({resp.b_valid, resp.b.resp}), 64'b100);
        tick();
        req = '0;
        tick();

        // Randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            bit wr;
            logic [3:0] id;
            logic [63:0] a;
            logic [7:0] len;
            logic [2:0] size;
            logic [1:0] burst;
            logic [1:0] er;
            wr = 1'($urandom_range(0, 1));
            id = 4'($urandom);
            a = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a[63:8] = '1;
            len = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom_range(1, 3));
            size = 3'($urandom_range(0, 4));
            burst = 2'($urandom_range(0, 2));
            er = model_err(len, size, burst) ? 2'b10 : 2'b00;
            if (wr) do_write(id, a, len, size, burst, er, 64'h0, 8'h0);
            else do_read(id, a, len, size, burst, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
